// File: rtl/gmii_rx_frame_extract_if.sv
// GMII receive input and byte-stream output of the frame extractor, bundled as one interface.
// The master modport is the extractor; the slave modport is the PHY/consumer environment.
interface gmii_rx_frame_extract_if;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv;
    logic       gmii_rx_er;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tlast;
    logic       m_axis_tuser;

    modport master (
        input  gmii_rxd, gmii_rx_dv, gmii_rx_er,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );

    modport slave (
        output gmii_rxd, gmii_rx_dv, gmii_rx_er,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );
endinterface

// File: rtl/gmii_rx_frame_extract.sv
// Strips preamble/SFD from GMII receive frames, forwards payload+FCS as a byte stream
// with one cycle of delay, and reports per-frame length and good/bad frame counts.
module gmii_rx_frame_extract #(
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1522
) (
    input  logic                    clk,
    input  logic                    rst_n,
    gmii_rx_frame_extract_if.master bus,
    output logic [15:0]             frame_len,
    output logic                    frame_len_valid,
    output logic [31:0]             cnt_good,
    output logic [31:0]             cnt_bad
);
    localparam logic [7:0]  PRE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE = 8'hD5;
    localparam logic [15:0] MIN_L    = 16'(MIN_FRAME_LEN);
    localparam logic [15:0] MAX_L    = 16'(MAX_FRAME_LEN);

    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DROP} state_t;

    state_t      r_state, w_next;
    logic [7:0]  r_hold;
    logic [15:0] r_len;
    logic        r_err;
    logic        r_armed;
    logic [7:0]  r_tdata;
    logic        r_tvalid, r_tlast, r_tuser;
    logic        w_emit, w_end, w_drop_end, w_sfd, w_bad;

    assign bus.m_axis_tdata  = r_tdata;
    assign bus.m_axis_tvalid = r_tvalid;
    assign bus.m_axis_tlast  = r_tlast;
    assign bus.m_axis_tuser  = r_tuser;

    assign w_bad = r_err | (r_len < MIN_L) | (r_len > MAX_L);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Until rx_dv has been seen low after reset, IDLE ignores the tail of any interrupted frame.
    always_comb begin
        w_next     = r_state;
        w_emit     = 1'b0;
        w_end      = 1'b0;
        w_drop_end = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.gmii_rx_dv && r_armed) begin
                    if (bus.gmii_rxd == PRE_BYTE)      w_next = PREAMBLE;
                    else if (bus.gmii_rxd == SFD_BYTE) w_next = PAYLOAD;
                    else                               w_next = DROP;
                end
            end
            PREAMBLE: begin
                if (!bus.gmii_rx_dv)                w_next = IDLE;
                else if (bus.gmii_rxd == SFD_BYTE)  w_next = PAYLOAD;
                else if (bus.gmii_rxd != PRE_BYTE)  w_next = DROP;
            end
            PAYLOAD: begin
                if (bus.gmii_rx_dv) begin
                    w_emit = (r_len != 16'd0);
                end else begin
                    w_next = IDLE;
                    w_end  = 1'b1;
                end
            end
            DROP: begin
                if (!bus.gmii_rx_dv) begin
                    w_next     = IDLE;
                    w_drop_end = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
        w_sfd = (w_next == PAYLOAD) && (r_state != PAYLOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold          <= 8'h00;
            r_len           <= 16'd0;
            r_err           <= 1'b0;
            r_armed         <= 1'b0;
            r_tdata         <= 8'h00;
            r_tvalid        <= 1'b0;
            r_tlast         <= 1'b0;
            r_tuser         <= 1'b0;
            frame_len       <= 16'd0;
            frame_len_valid <= 1'b0;
            cnt_good        <= 32'd0;
            cnt_bad         <= 32'd0;
        end else begin
            r_tvalid        <= 1'b0;
            r_tlast         <= 1'b0;
            r_tuser         <= 1'b0;
            frame_len_valid <= 1'b0;
            if (!bus.gmii_rx_dv) r_armed <= 1'b1;

            // An error flagged on the SFD byte itself already taints the frame.
            if (w_sfd) begin
                r_len <= 16'd0;
                r_err <= bus.gmii_rx_er;
            end

            if (r_state == PAYLOAD && bus.gmii_rx_dv) begin
                r_hold <= bus.gmii_rxd;
                r_len  <= (r_len == 16'hFFFF) ? r_len : r_len + 16'd1;
                r_err  <= r_err | bus.gmii_rx_er;
                if (w_emit) begin
                    r_tvalid <= 1'b1;
                    r_tdata  <= r_hold;
                end
            end

            if (w_end) begin
                r_len <= 16'd0;
                r_err <= 1'b0;
                if (r_len != 16'd0) begin
                    r_tvalid        <= 1'b1;
                    r_tdata         <= r_hold;
                    r_tlast         <= 1'b1;
                    r_tuser         <= w_bad;
                    frame_len       <= r_len;
                    frame_len_valid <= 1'b1;
                    if (w_bad) cnt_bad  <= cnt_bad + 32'd1;
                    else       cnt_good <= cnt_good + 32'd1;
                end else begin
                    cnt_bad <= cnt_bad + 32'd1;
                end
            end

            if (w_drop_end) cnt_bad <= cnt_bad + 32'd1;
        end
    end
endmodule

// File: tb/tb_gmii_rx_frame_extract.sv
// Randomized and directed bench for gmii_rx_frame_extract against a frame-level reference model.
module tb_gmii_rx_frame_extract;
    localparam int MIN_L = 64;
    localparam int MAX_L = 1522;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] frame_len;
    logic        frame_len_valid;
    logic [31:0] cnt_good, cnt_bad;

    gmii_rx_frame_extract_if bus();

    gmii_rx_frame_extract #(.MIN_FRAME_LEN(MIN_L), .MAX_FRAME_LEN(MAX_L)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .frame_len       (frame_len),
        .frame_len_valid (frame_len_valid),
        .cnt_good        (cnt_good),
        .cnt_bad         (cnt_bad)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int edge_n = 0;

    // Observed stream, collected on the falling edge.
    logic [7:0] act_q[$];
    int         act_last_n, act_last_idx, act_last_edge, act_flv_n, act_flv_alone;
    logic       act_tuser;
    logic [15:0] act_len;

    int exp_good = 0;
    int exp_bad  = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        act_q.delete();
        act_last_n    = 0;
        act_last_idx  = -1;
        act_last_edge = -1;
        act_flv_n     = 0;
        act_flv_alone = 0;
        act_tuser     = 1'b0;
        act_len       = 16'd0;
    endtask

    initial forever begin
        @(posedge clk);
        edge_n++;
    end

    initial forever begin
        @(negedge clk);
        if (bus.m_axis_tvalid === 1'b1) begin
            act_q.push_back(bus.m_axis_tdata);
            if (bus.m_axis_tlast === 1'b1) begin
                act_last_n++;
                act_last_idx  = act_q.size() - 1;
                act_last_edge = edge_n;
                act_tuser     = bus.m_axis_tuser;
            end
        end
        if (frame_len_valid === 1'b1) begin
            act_flv_n++;
            act_len = frame_len;
            if (bus.m_axis_tlast !== 1'b1) act_flv_alone++;
        end
    end

    task automatic cyc(input logic dv, input logic [7:0] d, input logic er);
        bus.gmii_rx_dv = dv;
        bus.gmii_rxd   = d;
        bus.gmii_rx_er = er;
        @(posedge clk);
        #1;
    endtask

    // Drives one burst of rx_dv=1 bytes followed by 'gap' idle cycles and checks it
    // against what the framing rules say should come out.
    task automatic run_frame(input string tag, input logic [7:0] b[$], input bit e[$], input int gap);
        logic [7:0] exp_q[$];
        int   i, n, plen, fall_edge;
        bit   err, bad, exp_last;
        logic [15:0] exp_len;
        n = b.size();
        i = 0;
        exp_last = 0;
        bad = 0;
        exp_len = 16'd0;
        while (i < n && b[i] == 8'h55) i++;
        if (i < n && b[i] == 8'hD5) begin
            plen = n - i - 1;
            err = 0;
            for (int k = i; k < n; k++) err |= e[k];
            if (plen == 0) exp_bad++;
            else begin
                for (int k = i + 1; k < n; k++) exp_q.push_back(b[k]);
                bad = err || plen < MIN_L || plen > MAX_L;
                exp_last = 1;
                exp_len = (plen > 65535) ? 16'hFFFF : 16'(plen);
                if (bad) exp_bad++; else exp_good++;
            end
        end else if (i < n) begin
            exp_bad++;
        end

        clear_mon();
        for (int k = 0; k < n; k++) cyc(1'b1, b[k], e[k]);
        cyc(1'b0, 8'($urandom), 1'($urandom));
        fall_edge = edge_n;
        for (int k = 1; k < gap; k++) cyc(1'b0, 8'($urandom), 1'($urandom));
        @(negedge clk);
        #1;

        check_val({tag, " beats"}, act_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < act_q.size(); k++)
            check_val($sformatf("%s byte%0d", tag, k), act_q[k], exp_q[k]);
        check_val({tag, " tlast_n"}, act_last_n, exp_last ? 1 : 0);
        check_val({tag, " flv_n"}, act_flv_n, exp_last ? 1 : 0);
        check_val({tag, " flv_alone"}, act_flv_alone, 0);
        if (exp_last) begin
            check_val({tag, " tlast_idx"}, act_last_idx, exp_q.size() - 1);
            check_val({tag, " tlast_edge"}, act_last_edge, fall_edge);
            check_val({tag, " tuser"}, act_tuser, bad);
            check_val({tag, " frame_len"}, act_len, exp_len);
        end
        check_val({tag, " cnt_good"}, cnt_good, exp_good);
        check_val({tag, " cnt_bad"}, cnt_bad, exp_bad);
    endtask

    task automatic build(input int npre, input bit sfd, input int plen, input int er_pos,
                         input bit seq, output logic [7:0] b[$], output bit e[$]);
        b.delete();
        e.delete();
        for (int k = 0; k < npre; k++) begin b.push_back(8'h55); e.push_back(1'b0); end
        if (sfd) begin b.push_back(8'hD5); e.push_back(1'b0); end
        for (int k = 0; k < plen; k++) begin
            b.push_back(seq ? 8'(k) : 8'($urandom));
            e.push_back(k == er_pos);
        end
    endtask

    initial begin
        logic [7:0] b[$];
        bit         e[$];
        logic [7:0] g;
        int         kind;

        bus.gmii_rx_dv = 1'b0;
        bus.gmii_rxd   = 8'h00;
        bus.gmii_rx_er = 1'b0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst tvalid", bus.m_axis_tvalid, 1'b0);
        check_val("rst tlast", bus.m_axis_tlast, 1'b0);
        check_val("rst tuser", bus.m_axis_tuser, 1'b0);
        check_val("rst tdata", bus.m_axis_tdata, 8'h00);
        check_val("rst frame_len", frame_len, 16'd0);
        check_val("rst flv", frame_len_valid, 1'b0);
        check_val("rst cnt_good", cnt_good, 32'd0);
        check_val("rst cnt_bad", cnt_bad, 32'd0);
        rst_n = 1'b1;
        repeat (2) cyc(1'b0, 8'h00, 1'b0);

        build(7, 1, 64, -1, 1, b, e);
        run_frame("basic64", b, e, 2);
        build(7, 1, 64, 10, 1, b, e);
        run_frame("er10", b, e, 2);
        build(7, 1, 40, -1, 0, b, e);
        run_frame("short40", b, e, 2);
        build(7, 1, 1600, -1, 0, b, e);
        run_frame("over1600", b, e, 2);
        b = '{8'h55, 8'h55, 8'h12, 8'h34, 8'h56};
        e = '{0, 0, 0, 0, 0};
        run_frame("drop", b, e, 2);
        build(7, 1, 0, -1, 0, b, e);
        run_frame("zero", b, e, 2);
        build(7, 1, 70, -1, 0, b, e);
        run_frame("b2b_a", b, e, 1);
        build(7, 1, 65, -1, 0, b, e);
        run_frame("b2b_b", b, e, 1);

        // Reset in the middle of a frame, then finish the interrupted burst and send a fresh frame.
        build(7, 1, 64, -1, 1, b, e);
        for (int k = 0; k < 8 + 30; k++) cyc(1'b1, b[k], 1'b0);
        bus.gmii_rxd = b[38];
        #2 rst_n = 1'b0;
        #1;
        clear_mon();
        exp_good = 0;
        exp_bad  = 0;
        check_val("mid_rst tvalid", bus.m_axis_tvalid, 1'b0);
        check_val("mid_rst tlast", bus.m_axis_tlast, 1'b0);
        check_val("mid_rst tdata", bus.m_axis_tdata, 8'h00);
        check_val("mid_rst frame_len", frame_len, 16'd0);
        check_val("mid_rst cnt_good", cnt_good, 32'd0);
        check_val("mid_rst cnt_bad", cnt_bad, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 39; k < b.size(); k++) cyc(1'b1, b[k], 1'b0);
        repeat (2) cyc(1'b0, 8'h00, 1'b0);
        check_val("post_rst beats", act_q.size(), 0);
        check_val("post_rst tlast_n", act_last_n, 0);
        build(7, 1, 64, -1, 1, b, e);
        run_frame("after_rst", b, e, 2);

        for (int r = 0; r < 40; r++) begin
            kind = $urandom_range(0, 5);
            case (kind)
                0: build($urandom_range(0, 7), 1, $urandom_range(64, 150), -1, 0, b, e);
                1: build($urandom_range(0, 7), 1, $urandom_range(64, 150), $urandom_range(0, 63), 0, b, e);
                2: build($urandom_range(0, 7), 1, $urandom_range(1, 63), -1, 0, b, e);
                3: begin
                    build($urandom_range(0, 3), 0, 0, -1, 0, b, e);
                    do g = 8'($urandom); while (g == 8'h55 || g == 8'hD5);
                    b.push_back(g);
                    e.push_back(1'b0);
                    for (int k = 0; k < 5; k++) begin b.push_back(8'($urandom)); e.push_back(1'b0); end
                end
                4: build($urandom_range(0, 7), 1, 0, -1, 0, b, e);
                default: build($urandom_range(1, 7), 0, 0, -1, 0, b, e);
            endcase
            run_frame($sformatf("rnd%0d", r), b, e, $urandom_range(1, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/gmii_rx_frame_extract.md
GMII_RX_FRAME_EXTRACT -- requirements
Module: gmii_rx_frame_extract

Interface
REQ-001 SHALL have parameter MIN_FRAME_LEN, default 64, meaning minimum legal frame length in bytes after SFD, FCS included.
REQ-002 SHALL have parameter MAX_FRAME_LEN, default 1522, meaning maximum legal frame length in bytes after SFD, FCS included.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-004 clk  input  1  GMII receive clock; all logic on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 gmii_rxd  input  8  GMII receive data from the PHY bridge interface.
REQ-007 gmii_rx_dv  input  1  receive data valid.
REQ-008 gmii_rx_er  input  1  receive error.
REQ-009 m_axis_tdata  output  8  frame byte (preamble/SFD stripped, FCS kept).
REQ-010 m_axis_tvalid  output  1  byte valid; no backpressure exists.
REQ-011 m_axis_tlast  output  1  last byte of frame.
REQ-012 m_axis_tuser  output  1  frame bad, qualified by tlast.
REQ-013 frame_len  output  16  length of the frame just ended.
REQ-014 frame_len_valid  output  1  one-cycle strobe, frame_len valid.
REQ-015 cnt_good  output  32  good-frame counter.
REQ-016 cnt_bad  output  32  bad/aborted-frame counter.

Function
REQ-017 SHALL implement FSM states IDLE, PREAMBLE, PAYLOAD, DROP.
REQ-018 IDLE: rx_dv=1 with rxd=0x55 -> PREAMBLE; rx_dv=1 with rxd=0xD5 -> PAYLOAD; rx_dv=1 with any other value -> DROP; rx_dv=0 -> stay.
REQ-019 PREAMBLE: rx_dv=1 with 0x55 -> stay; 0xD5 -> PAYLOAD; other value -> DROP; rx_dv=0 -> IDLE, with no output and no counter change.
REQ-020 PAYLOAD: each byte sampled with rx_dv=1 SHALL be loaded into a one-byte holding register, and the previously held byte, if any, SHALL be emitted with tvalid=1, tlast=0.
REQ-021 PAYLOAD with rx_dv=0: the held byte SHALL be emitted with tvalid=1, tlast=1 and tuser=bad; FSM -> IDLE in the same edge.
REQ-022 Output latency: byte N SHALL appear on the edge that samples byte N+1 or the first rx_dv=0, giving exactly one clock of delay in continuous reception.
REQ-023 The length counter SHALL count bytes sampled in PAYLOAD, saturating at 0xFFFF.
REQ-024 bad SHALL be 1 if rx_er=1 with rx_dv=1 at any cycle from the SFD to frame end, or if length<MIN_FRAME_LEN, or if length>MAX_FRAME_LEN.
REQ-025 Oversize frames SHALL continue to be forwarded until rx_dv falls, then be flagged bad.
REQ-026 At frame end, frame_len SHALL be set to the final length and frame_len_valid SHALL pulse for one cycle, coincident with tlast.
REQ-027 At frame end, exactly one of cnt_good or cnt_bad SHALL increment by 1, coincident with tlast; both counters wrap modulo 2^32.
REQ-028 An SFD followed immediately by rx_dv=0 (zero-byte frame) SHALL emit no beat, SHALL not pulse frame_len_valid, SHALL increment cnt_bad, and FSM -> IDLE.
REQ-029 DROP: SHALL emit nothing; on rx_dv=0, SHALL increment cnt_bad once and FSM -> IDLE.
REQ-030 rx_er with rx_dv=0 (carrier extension/false carrier) SHALL be ignored in all states.
REQ-031 m_axis_tvalid, tlast, tuser and frame_len_valid SHALL be asserted only for single cycles, as the events above dictate, and be 0 otherwise.

Reset
REQ-032 On rst_n=0 (asynchronous): state=IDLE; tdata=0x00; tvalid=0; tlast=0; tuser=0; frame_len=0; frame_len_valid=0; cnt_good=0; cnt_bad=0; holding register and length counter cleared.
REQ-033 Reset asserted mid-frame SHALL discard the partial frame without a tlast beat; after release, the block SHALL require a fresh rx_dv=0 -> preamble/SFD sequence before emitting.
REQ-034 Release of rst_n SHALL be synchronised to clk externally; the block SHALL not rely on any other reset.

Verification
REQ-035 7x0x55, 0xD5, 64 bytes 0x00..0x3F, then rx_dv=0 -> 64 beats 0x00..0x3F, tlast on 0x3F, tuser=0, frame_len=64, cnt_good=1.
REQ-036 Same frame with rx_er=1 on payload byte 10 -> 64 beats, tuser=1 at tlast, cnt_bad=1, cnt_good unchanged.
REQ-037 Preamble+SFD+40 bytes -> tuser=1, frame_len=40; preamble+SFD+1600 bytes -> 1600 beats, tuser=1, frame_len=1600.
REQ-038 rx_dv=1 with 0x55,0x55,0x12,... -> no beats, cnt_bad=1 after rx_dv falls; SFD then immediate rx_dv=0 -> no beats, no frame_len_valid, cnt_bad+1.
REQ-039 Back-to-back frames separated by one idle cycle -> both emitted intact with correct tlast and frame_len values.
REQ-040 rst_n pulsed low at payload byte 30 -> all outputs 0 immediately, no tlast; the next full frame is emitted correctly, cnt_good=1.
